armleocpu_store_unit: RTL and testbench
=======================================

# armleocpu_store_unit

Store-path sequencer between the execute stage and the data-memory write port. Accepts one store request at a time, checks alignment and type, lane-aligns data and builds the byte mask, then runs a single write transaction on a valid/ready bus. Reports one status per request back to execute.

## Interface
Parameters:
- none (address 32 bits, data 32 bits, fixed)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  store request present
- req_ready  out  1  block can accept a request
- req_addr  in  32  byte address
- req_type  in  2  00 byte, 01 half, 10 word, 11 unknown
- req_data  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle status pulse, no backpressure
- rsp_status  out  2  00 ok, 01 misaligned, 10 unknown type, 11 bus error; valid only with rsp_valid
- bus_wvalid  out  1  write request
- bus_wready  in  1  bus accepts write
- bus_waddr  out  32  word address, bits [1:0] always 00
- bus_wdata  out  32  lane-aligned data
- bus_wstrb  out  4  byte enables
- bus_bvalid  in  1  write response present
- bus_bresp  in  2  00 ok, anything else error
- bus_bready  out  1  block accepts response

## Operation
- States: IDLE, WREQ, WRESP, RSP (plus WREQ2, WRESP2 with split enabled).
- IDLE: req_ready=1. On req_valid, the request is captured; offset = req_addr[1:0].
- Check at capture, priority order: type 11 -> status 10; word with offset!=0 or half with offset[0]=1 -> status 01. Either case -> RSP, no bus activity.
- Legal request -> WREQ. bus_waddr={req_addr[31:2],2'b00}; bus_wdata=req_data<<(8*offset).
- bus_wstrb: byte 0001<<offset, half 0011<<offset, word 1111.
- WREQ: bus_wvalid=1, payload stable until bus_wready. On wready -> WRESP.
- WRESP: bus_bready=1. On bvalid -> RSP; status 00 if bresp==00, else 11.
- RSP: rsp_valid=1 for exactly one cycle, then IDLE.
- Outputs are registered from state and captured request only. No combinational path from req_* to bus_* or rsp_*.
- bus_bvalid outside WRESP/WRESP2 is ignored because bus_bready=0.

## Timing
- Reset values: req_ready=0 during reset, then 1 (IDLE) the cycle after rst_n rises. rsp_valid=0, rsp_status=00, bus_wvalid=0, bus_waddr=0, bus_wdata=0, bus_wstrb=0, bus_bready=0.
- Legal store, zero wait: accept edge cycle 0; wvalid cycle 1 with wready; bready cycle 2 with bvalid; rsp_valid cycle 3; req_ready cycle 4.
- Error store: accept cycle 0, rsp_valid cycle 1, req_ready cycle 2.
- Throughput: one request per 4 cycles minimum (2 for errors).
- Wait states on wready or bvalid extend WREQ or WRESP indefinitely. There is no timeout.
- rst_n low in any state returns to IDLE at the next edge and drops bus_wvalid and bus_bready immediately. The in-flight request is discarded and no rsp_valid is emitted.

## Configuration
- ARMLEOCPU_STORE_UNIT_SPLIT_EN undefined:
  - misaligned half/word reports status 01 as above.
- ARMLEOCPU_STORE_UNIT_SPLIT_EN defined:
  - misaligned half/word is never an error; it is issued as two bus writes.
  - Let m8 = typemask<<offset, an 8-bit value where typemask is 0011 or 1111.
  - Beat 1: addr A={req_addr[31:2],00}, strb m8[3:0], data req_data<<(8*offset).
  - Beat 2: addr A+4 (wraps modulo 2^32), strb m8[7:4], data req_data>>(8*(4-offset)).
  - Sequence: WREQ, WRESP, WREQ2, WRESP2, RSP.
  - A bus error on beat 1 skips beat 2 and reports 11.
  - Unknown type still reports 10. Aligned stores are unchanged.

## Test plan
- Aligned word: addr 0x1000, type 10, data 0xDEADBEEF, zero wait -> waddr 0x1000, wdata 0xDEADBEEF, wstrb 1111; rsp_valid cycle 3, status 00.
- Byte lane shift: addr 0x2003, type 00, data 0x000000AB -> waddr 0x2000, wdata 0xAB000000, wstrb 1000, status 00.
- Half at offset 2, wready low 3 cycles, bvalid low 2 cycles: data 0x1234 -> wdata 0x12340000, wstrb 1100 held stable; rsp_valid 5 cycles later than zero-wait.
- Errors:
  - word at 0x3002 -> status 01 in cycle 1, bus_wvalid never asserted.
  - type 11 at 0x3002 -> status 10.
  - aligned word with bresp 10 -> status 11.
- Reset in WRESP: rst_n low 1 cycle -> wvalid/bready 0, no rsp_valid, req_ready 1 next cycle. A stray bvalid afterwards is ignored.
- SPLIT_EN: word at 0xFFFFFFFE, data 0xAABBCCDD:
  - beat 1: waddr 0xFFFFFFFC, wdata 0xCCDD0000, strb 1100.
  - beat 2: waddr 0x00000000, wdata 0x0000AABB, strb 0011.
  - status 00. With beat-1 bresp 10: status 11, only one write issued.

Source files
------------

// File: rtl/armleocpu_store_unit.sv
// rtl/armleocpu_store_unit.sv - store-path sequencer: type/alignment check, lane alignment, byte strobes, one bus write per request
// Optional feature macro ARMLEOCPU_STORE_UNIT_SPLIT_EN issues misaligned half/word stores as two bus writes.
module armleocpu_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic        bus_wvalid,
    input  logic        bus_wready,
    output logic [31:0] bus_waddr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_bvalid,
    input  logic [1:0]  bus_bresp,
    output logic        bus_bready
);
    localparam logic [1:0] TYPE_BYTE      = 2'b00;
    localparam logic [1:0] TYPE_HALF      = 2'b01;
    localparam logic [1:0] TYPE_WORD      = 2'b10;
    localparam logic [1:0] TYPE_UNKNOWN   = 2'b11;
    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_MISALIGN= 2'b01;
    localparam logic [1:0] STATUS_UNKNOWN = 2'b10;
    localparam logic [1:0] STATUS_BUSERR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WREQ  = 3'd1,
        WRESP = 3'd2,
        RSP   = 3'd3
`ifdef ARMLEOCPU_STORE_UNIT_SPLIT_EN
        ,
        WREQ2  = 3'd4,
        WRESP2 = 3'd5
`endif
    } state_t;

    state_t     state;
    logic [1:0] offset;
    logic [4:0] shiftBits;
    logic [3:0] typeMask;
    logic       misaligned;
    logic [31:0] wordAddr;
    logic [1:0] brespStatus;

`ifdef ARMLEOCPU_STORE_UNIT_SPLIT_EN
    logic [7:0]  laneMask;
    logic [63:0] laneData;
    logic        splitPending;
    logic [31:0] beat2Addr;
    logic [31:0] beat2Data;
    logic [3:0]  beat2Strb;
`else
    logic [3:0]  laneMask;
    logic [31:0] laneData;
`endif

    assign offset    = req_addr[1:0];
    assign shiftBits = {offset, 3'b000};
    assign wordAddr  = {req_addr[31:2], 2'b00};

    always_comb begin
        case (req_type)
            TYPE_BYTE: typeMask = 4'b0001;
            TYPE_HALF: typeMask = 4'b0011;
            default:   typeMask = 4'b1111;
        endcase
    end

    assign misaligned = ((req_type == TYPE_WORD) && (offset != 2'b00))
                     || ((req_type == TYPE_HALF) && offset[0]);

    assign brespStatus = (bus_bresp == 2'b00) ? STATUS_OK : STATUS_BUSERR;

`ifdef ARMLEOCPU_STORE_UNIT_SPLIT_EN
    // The upper half of the widened shift is exactly the spill-over into the next word.
    assign laneMask = {4'b0000, typeMask} << offset;
    assign laneData = {32'h0000_0000, req_data} << shiftBits;
`else
    assign laneMask = typeMask << offset;
    assign laneData = req_data << shiftBits;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= STATUS_OK;
            bus_wvalid <= 1'b0;
            bus_waddr  <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_wstrb  <= 4'h0;
            bus_bready <= 1'b0;
`ifdef ARMLEOCPU_STORE_UNIT_SPLIT_EN
            splitPending <= 1'b0;
            beat2Addr    <= 32'h0;
            beat2Data    <= 32'h0;
            beat2Strb    <= 4'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready && req_valid) begin
                        req_ready <= 1'b0;
                        if (req_type == TYPE_UNKNOWN) begin
                            state      <= RSP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= STATUS_UNKNOWN;
`ifndef ARMLEOCPU_STORE_UNIT_SPLIT_EN
                        end else if (misaligned) begin
                            state      <= RSP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= STATUS_MISALIGN;
`endif
                        end else begin
                            state      <= WREQ;
                            bus_wvalid <= 1'b1;
                            bus_waddr  <= wordAddr;
                            bus_wdata  <= laneData[31:0];
                            bus_wstrb  <= laneMask[3:0];
`ifdef ARMLEOCPU_STORE_UNIT_SPLIT_EN
                            splitPending <= misaligned;
                            beat2Addr    <= wordAddr + 32'd4;
                            beat2Data    <= laneData[63:32];
                            beat2Strb    <= laneMask[7:4];
`endif
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WREQ: begin
                    if (bus_wready) begin
                        bus_wvalid <= 1'b0;
                        bus_bready <= 1'b1;
                        state      <= WRESP;
                    end
                end
                WRESP: begin
                    if (bus_bvalid) begin
                        bus_bready <= 1'b0;
`ifdef ARMLEOCPU_STORE_UNIT_SPLIT_EN
                        // A failed first beat ends the request without touching the next word.
                        if (splitPending && (bus_bresp == 2'b00)) begin
                            state      <= WREQ2;
                            bus_wvalid <= 1'b1;
                            bus_waddr  <= beat2Addr;
                            bus_wdata  <= beat2Data;
                            bus_wstrb  <= beat2Strb;
                        end else begin
                            state      <= RSP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= brespStatus;
                        end
`else
                        state      <= RSP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= brespStatus;
`endif
                    end
                end
`ifdef ARMLEOCPU_STORE_UNIT_SPLIT_EN
                WREQ2: begin
                    if (bus_wready) begin
                        bus_wvalid <= 1'b0;
                        bus_bready <= 1'b1;
                        state      <= WRESP2;
                    end
                end
                WRESP2: begin
                    if (bus_bvalid) begin
                        bus_bready <= 1'b0;
                        state      <= RSP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= brespStatus;
                    end
                end
`endif
                RSP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b0;
                    rsp_valid  <= 1'b0;
                    bus_wvalid <= 1'b0;
                    bus_bready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_armleocpu_store_unit.sv
// tb/tb_armleocpu_store_unit.sv - table-driven scoreboard bench for armleocpu_store_unit
module tb_armleocpu_store_unit;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_type;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic        bus_wvalid;
    logic        bus_wready;
    logic [31:0] bus_waddr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_bvalid;
    logic [1:0]  bus_bresp;
    logic        bus_bready;

    armleocpu_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_type(req_type), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .bus_wvalid(bus_wvalid), .bus_wready(bus_wready), .bus_waddr(bus_waddr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_bvalid(bus_bvalid), .bus_bresp(bus_bresp), .bus_bready(bus_bready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [31:0] data;
        int          wWait;
        int          bWait;
        logic [1:0]  bresp;
        int          nBeats;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [3:0]  s0;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [3:0]  s1;
        logic [1:0]  status;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } beat_t;

    typedef struct {
        logic [1:0] status;
        int         cyc;
    } rsp_t;

    beat_t beatQ[$];
    rsp_t  rspQ[$];
    vec_t  vecs[$];

    int nCompared = 0;
    int nMismatch = 0;
    int cyc = 0;
    int curVec = -1;
    int wWaitCfg, bWaitCfg;
    logic [1:0] brespCfg;
    logic strayB;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s (vec %0d): got 0x%08h required 0x%08h", name, curVec, act, exp);
        end
    endfunction

    function automatic void noteFail(input string name);
        nCompared++;
        nMismatch++;
        $display("FAIL %s (vec %0d): event not allowed here", name, curVec);
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] typ, input logic [31:0] data,
                                input int wWait, input int bWait, input logic [1:0] bresp, input int nBeats,
                                input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                                input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1,
                                input logic [1:0] status);
        vec_t v;
        v.addr = addr; v.typ = typ; v.data = data; v.wWait = wWait; v.bWait = bWait;
        v.bresp = bresp; v.nBeats = nBeats; v.a0 = a0; v.d0 = d0; v.s0 = s0;
        v.a1 = a1; v.d1 = d1; v.s1 = s1; v.status = status;
        return v;
    endfunction

    // Bus slave model: wait-state counters plus an optional stray bvalid.
    initial begin
        int wCnt;
        int bCnt;
        wCnt = 0;
        bCnt = 0;
        bus_wready = 1'b0;
        bus_bvalid = 1'b0;
        bus_bresp  = 2'b00;
        forever begin
            @(negedge clk);
            if (bus_wvalid) begin
                bus_wready = (wCnt >= wWaitCfg);
                wCnt++;
            end else begin
                bus_wready = 1'b0;
                wCnt = 0;
            end
            if (bus_bready) begin
                bus_bvalid = (bCnt >= bWaitCfg);
                bCnt++;
            end else begin
                bus_bvalid = strayB;
                bCnt = 0;
            end
            bus_bresp = brespCfg;
        end
    end

    // Scoreboard monitor: write payload checked every cycle wvalid is up, popped on handshake.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus_wvalid) begin
                if (beatQ.size() == 0) begin
                    noteFail("unexpected_write");
                end else begin
                    check("waddr", bus_waddr, beatQ[0].addr);
                    check("wdata", bus_wdata, beatQ[0].data);
                    check("wstrb", {28'h0, bus_wstrb}, {28'h0, beatQ[0].strb});
                    if (bus_wready) void'(beatQ.pop_front());
                end
            end
            if (rsp_valid) begin
                if (rspQ.size() == 0) begin
                    noteFail("unexpected_rsp");
                end else begin
                    rsp_t r;
                    r = rspQ.pop_front();
                    check("rsp_status", {30'h0, rsp_status}, {30'h0, r.status});
                    check("rsp_cycle", cyc, r.cyc);
                end
            end
        end
    end

    task automatic issue(input vec_t v, input bit expectRsp);
        int guard;
        beat_t b;
        rsp_t r;
        guard = 0;
        wWaitCfg = v.wWait;
        bWaitCfg = v.bWait;
        brespCfg = v.bresp;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_before_issue", {31'h0, req_ready}, 32'h1);
        if (v.nBeats > 0) begin
            b.addr = v.a0; b.data = v.d0; b.strb = v.s0;
            beatQ.push_back(b);
        end
        if (v.nBeats > 1) begin
            b.addr = v.a1; b.data = v.d1; b.strb = v.s1;
            beatQ.push_back(b);
        end
        if (expectRsp) begin
            r.status = v.status;
            r.cyc = cyc + 1 + 2 * v.nBeats + v.nBeats * (v.wWait + v.bWait);
            rspQ.push_back(r);
        end
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_type  = v.typ;
        req_data  = v.data;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_type  = 2'($urandom);
        req_data  = $urandom;
    endtask

    task automatic waitRsp();
        int guard;
        guard = 0;
        while (rspQ.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (rspQ.size() != 0) begin
            noteFail("rsp_timeout");
            rspQ.delete();
            beatQ.delete();
        end
        check("beats_drained", beatQ.size(), 32'h0);
        check("rsp_single_pulse", {31'h0, rsp_valid}, 32'h0);
        check("req_ready_after_rsp", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        int guard;
        vec_t rv;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = 32'h0;
        req_type = 2'b00;
        req_data = 32'h0;
        strayB = 1'b0;
        wWaitCfg = 0;
        bWaitCfg = 0;
        brespCfg = 2'b00;

        vecs.push_back(mk(32'h0000_1000, 2'b10, 32'hDEAD_BEEF, 0, 0, 2'b00, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'h0, 4'h0, 2'b00));
        vecs.push_back(mk(32'h0000_2003, 2'b00, 32'h0000_00AB, 0, 0, 2'b00, 1, 32'h0000_2000, 32'hAB00_0000, 4'h8, 32'h0, 32'h0, 4'h0, 2'b00));
        vecs.push_back(mk(32'h0000_2002, 2'b01, 32'h0000_1234, 3, 2, 2'b00, 1, 32'h0000_2000, 32'h1234_0000, 4'hC, 32'h0, 32'h0, 4'h0, 2'b00));
`ifdef ARMLEOCPU_STORE_UNIT_SPLIT_EN
        vecs.push_back(mk(32'h0000_3002, 2'b10, 32'hDEAD_BEEF, 0, 0, 2'b00, 2, 32'h0000_3000, 32'hBEEF_0000, 4'hC, 32'h0000_3004, 32'h0000_DEAD, 4'h3, 2'b00));
`else
        vecs.push_back(mk(32'h0000_3002, 2'b10, 32'hDEAD_BEEF, 0, 0, 2'b00, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'b01));
`endif
        vecs.push_back(mk(32'h0000_3002, 2'b11, 32'h0000_0000, 0, 0, 2'b00, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'b10));
        vecs.push_back(mk(32'h0000_4000, 2'b10, 32'h1234_5678, 0, 0, 2'b10, 1, 32'h0000_4000, 32'h1234_5678, 4'hF, 32'h0, 32'h0, 4'h0, 2'b11));
        vecs.push_back(mk(32'h0000_5001, 2'b00, 32'hFFFF_FF5A, 1, 0, 2'b00, 1, 32'h0000_5000, 32'hFFFF_5A00, 4'h2, 32'h0, 32'h0, 4'h0, 2'b00));
        vecs.push_back(mk(32'h0000_6000, 2'b01, 32'h0000_CAFE, 0, 1, 2'b00, 1, 32'h0000_6000, 32'h0000_CAFE, 4'h3, 32'h0, 32'h0, 4'h0, 2'b00));
`ifdef ARMLEOCPU_STORE_UNIT_SPLIT_EN
        vecs.push_back(mk(32'h0000_6003, 2'b01, 32'h0000_CAFE, 0, 0, 2'b00, 2, 32'h0000_6000, 32'hFE00_0000, 4'h8, 32'h0000_6004, 32'h0000_00CA, 4'h1, 2'b00));
`else
        vecs.push_back(mk(32'h0000_6003, 2'b01, 32'h0000_CAFE, 0, 0, 2'b00, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'b01));
`endif
        vecs.push_back(mk(32'h0000_7000, 2'b01, 32'h0000_BEEF, 0, 0, 2'b01, 1, 32'h0000_7000, 32'h0000_BEEF, 4'h3, 32'h0, 32'h0, 4'h0, 2'b11));
        vecs.push_back(mk(32'h0000_7000, 2'b11, 32'hFFFF_FFFF, 0, 0, 2'b00, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'b10));
        vecs.push_back(mk(32'hFFFF_FFFC, 2'b10, 32'h0102_0304, 1, 1, 2'b00, 1, 32'hFFFF_FFFC, 32'h0102_0304, 4'hF, 32'h0, 32'h0, 4'h0, 2'b00));
`ifdef ARMLEOCPU_STORE_UNIT_SPLIT_EN
        vecs.push_back(mk(32'hFFFF_FFFE, 2'b10, 32'hAABB_CCDD, 0, 0, 2'b00, 2, 32'hFFFF_FFFC, 32'hCCDD_0000, 4'hC, 32'h0000_0000, 32'h0000_AABB, 4'h3, 2'b00));
        vecs.push_back(mk(32'hFFFF_FFFE, 2'b10, 32'hAABB_CCDD, 0, 0, 2'b10, 1, 32'hFFFF_FFFC, 32'hCCDD_0000, 4'hC, 32'h0, 32'h0, 4'h0, 2'b11));
`else
        vecs.push_back(mk(32'hFFFF_FFFE, 2'b10, 32'hAABB_CCDD, 0, 0, 2'b00, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'b01));
        vecs.push_back(mk(32'hFFFF_FFFE, 2'b10, 32'hAABB_CCDD, 0, 0, 2'b10, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'b01));
`endif
        vecs.push_back(mk(32'h0000_0000, 2'b00, 32'h0000_0011, 0, 0, 2'b00, 1, 32'h0000_0000, 32'h0000_0011, 4'h1, 32'h0, 32'h0, 4'h0, 2'b00));
        vecs.push_back(mk(32'h0000_8002, 2'b01, 32'h0000_7777, 2, 0, 2'b11, 1, 32'h0000_8000, 32'h7777_0000, 4'hC, 32'h0, 32'h0, 4'h0, 2'b11));

        repeat (3) @(negedge clk);
        check("reset_req_ready", {31'h0, req_ready}, 32'h0);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_status", {30'h0, rsp_status}, 32'h0);
        check("reset_wvalid", {31'h0, bus_wvalid}, 32'h0);
        check("reset_waddr", bus_waddr, 32'h0);
        check("reset_wdata", bus_wdata, 32'h0);
        check("reset_wstrb", {28'h0, bus_wstrb}, 32'h0);
        check("reset_bready", {31'h0, bus_bready}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            curVec = i;
            issue(vecs[i], 1'b1);
            waitRsp();
        end

        // Reset while waiting in WRESP: request is dropped silently.
        curVec = 100;
        rv = mk(32'h0000_9000, 2'b10, 32'h55AA_55AA, 0, 1000, 2'b00, 1, 32'h0000_9000, 32'h55AA_55AA, 4'hF, 32'h0, 32'h0, 4'h0, 2'b00);
        issue(rv, 1'b0);
        guard = 0;
        while (!bus_bready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("wresp_reached", {31'h0, bus_bready}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bWaitCfg = 0;
        check("midreset_wvalid", {31'h0, bus_wvalid}, 32'h0);
        check("midreset_bready", {31'h0, bus_bready}, 32'h0);
        check("midreset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("beats_after_midreset", beatQ.size(), 32'h0);
        @(negedge clk);
        check("req_ready_after_midreset", {31'h0, req_ready}, 32'h1);

        strayB = 1'b1;
        brespCfg = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stray_bready", {31'h0, bus_bready}, 32'h0);
            check("stray_req_ready", {31'h0, req_ready}, 32'h1);
        end
        strayB = 1'b0;
        @(negedge clk);

        curVec = 101;
        issue(vecs[0], 1'b1);
        waitRsp();

        check("final_beatq_empty", beatQ.size(), 32'h0);
        check("final_rspq_empty", rspQ.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
